// File: rtl/imem_pkg.sv
// Shared types and defaults for the
// instruction-memory load controller.
package imem_pkg;

   localparam int          ADDR_W_DEF = 10;
   localparam logic [31:0] NOP_DEF    = 32'h0000_0013;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Single-port instruction memory bus
// (sync read, one cycle latency).
interface imem_load_ctrl_if #(
   parameter int ADDR_W = 10
) ();

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs loader bytes LSB-first into words;
// flush emits a zero-padded partial word.
module imem_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        take,
   input  logic        flush,
   input  logic [7:0]  din,
   output logic        word_go,
   output logic [31:0] word
);

   logic [1:0]  cnt;
   logic [1:0]  cnt_n;
   logic [31:0] pack;
   logic [31:0] merged;

   // merge the incoming byte; pack is kept zero above cnt
   always_comb begin
      merged = pack;
      if (take) merged[8*cnt +: 8] = din;
      cnt_n = take ? cnt + 2'd1 : cnt;
      word_go = (take && cnt == 2'd3) ||
                (flush && cnt_n != 2'd0);
      word = merged;
   end

   // byte counter and partial-word register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= 2'd0;
         pack <= 32'd0;
      end else if (clr || word_go) begin
         cnt  <= 2'd0;
         pack <= 32'd0;
      end else if (take) begin
         cnt  <= cnt_n;
         pack <= merged;
      end
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-loads the instruction memory, then
// serves IF-stage fetches from the same port.
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld_start,
   input  logic            ld_byte_valid,
   input  logic [7:0]      ld_byte,
   input  logic            ld_done,
   output logic [ADDR_W:0] ld_words,
   output logic            ld_overflow,
   output logic            core_hold,
   input  logic [31:0]     pc,
   output logic [31:0]     instr,
   output logic            instr_valid,
   output logic            fetch_fault,
   imem_load_ctrl_if.master mem
);

   localparam logic [ADDR_W:0] DEPTH =
      {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic              done_pend;
   logic [ADDR_W:0]   wr_ptr;
   logic              ovf;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              valid_q;
   logic              fault_q;

   logic        load;
   logic        full;
   logic        idle_ld;
   logic        take;
   logic        flush;
   logic        bad_pc;
   logic        word_go;
   logic [31:0] word;

   assign load    = (state == LOAD);
   assign full    = (wr_ptr == DEPTH);
   assign idle_ld = load && !done_pend && !ld_start;
   assign take    = idle_ld && ld_byte_valid && !full;
   assign flush   = idle_ld && ld_done;
   assign bad_pc  = (pc[1:0] != 2'd0) ||
                    (pc[31:ADDR_W+2] != '0);

   imem_byte_packer u_pack (
      .clk     (clk),
      .rst     (rst),
      .clr     (ld_start),
      .take    (take),
      .flush   (flush),
      .din     (ld_byte),
      .word_go (word_go),
      .word    (word)
   );

   // load/run FSM, write pointer, fetch-return flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD;
         done_pend <= 1'b0;
         wr_ptr    <= '0;
         ovf       <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= 32'd0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         unique case (state)
            LOAD: begin
               valid_q <= 1'b0;
               fault_q <= 1'b0;
               if (ld_start) begin
                  wr_ptr    <= '0;
                  ovf       <= 1'b0;
                  done_pend <= 1'b0;
               end else if (done_pend) begin
                  done_pend <= 1'b0;
                  state     <= RUN;
               end else begin
                  if (ld_byte_valid && full)
                     ovf <= 1'b1;
                  if (word_go) begin
                     we_q    <= 1'b1;
                     waddr_q <= wr_ptr[ADDR_W-1:0];
                     wdata_q <= word;
                     wr_ptr  <= wr_ptr + 1'b1;
                  end
                  if (ld_done) begin
                     if (word_go) done_pend <= 1'b1;
                     else         state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (ld_start) begin
                  state   <= LOAD;
                  wr_ptr  <= '0;
                  ovf     <= 1'b0;
                  valid_q <= 1'b0;
                  fault_q <= 1'b0;
               end else begin
                  valid_q <= 1'b1;
                  fault_q <= bad_pc;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign ld_words      = wr_ptr;
   assign ld_overflow   = ovf;
   assign core_hold     = load;
   assign mem.mem_we    = we_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_addr  = load ? waddr_q
                               : pc[ADDR_W+1:2];

   // memory output register is the instr register;
   // registered flags select it or the NOP
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;
   assign instr = (valid_q && !fault_q) ?
                  mem.mem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed + randomized bench for imem_load_ctrl
// with a word-image reference model.
module tb_imem_load_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        st0, bv0, dn0;
   logic [7:0]  b0;
   logic [31:0] pc0, in0;
   logic [10:0] w0;
   logic        ov0, h0, iv0, ff0;

   logic        st1, bv1, dn1;
   logic [7:0]  b1;
   logic [31:0] pc1, in1;
   logic [2:0]  w1;
   logic        ov1, h1, iv1, ff1;

   imem_load_ctrl_if #(.ADDR_W(10)) m0 ();
   imem_load_ctrl_if #(.ADDR_W(2))  m1 ();

   imem_load_ctrl #(.ADDR_W(10)) u0 (
      .clk(clk), .rst(rst), .ld_start(st0),
      .ld_byte_valid(bv0), .ld_byte(b0),
      .ld_done(dn0), .ld_words(w0),
      .ld_overflow(ov0), .core_hold(h0),
      .pc(pc0), .instr(in0), .instr_valid(iv0),
      .fetch_fault(ff0), .mem(m0)
   );

   imem_load_ctrl #(.ADDR_W(2)) u1 (
      .clk(clk), .rst(rst), .ld_start(st1),
      .ld_byte_valid(bv1), .ld_byte(b1),
      .ld_done(dn1), .ld_words(w1),
      .ld_overflow(ov1), .core_hold(h1),
      .pc(pc1), .instr(in1), .instr_valid(iv1),
      .fetch_fault(ff1), .mem(m1)
   );

   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [4];
   logic [41:0] wq0 [$];
   logic [33:0] wq1 [$];

   // behavioural sync-read memories with write logs
   always @(posedge clk) begin
      if (m0.mem_we) begin
         mem0[m0.mem_addr] <= m0.mem_wdata;
         wq0.push_back({m0.mem_addr, m0.mem_wdata});
      end
      m0.mem_rdata <= mem0[m0.mem_addr];
      if (m1.mem_we) begin
         mem1[m1.mem_addr] <= m1.mem_wdata;
         wq1.push_back({m1.mem_addr, m1.mem_wdata});
      end
      m1.mem_rdata <= mem1[m1.mem_addr];
   end

   int ncmp = 0;
   int nfail = 0;
   logic [31:0] ref_img [1024];

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [7:0] b,
                        input logic done);
      bv0 = 1'b1; b0 = b; dn0 = done;
      tick();
      bv0 = 1'b0; dn0 = 1'b0;
   endtask

   task automatic send1(input logic [7:0] b);
      bv1 = 1'b1; b1 = b;
      tick();
      bv1 = 1'b0;
   endtask

   task automatic chk_reset0();
      chk("rst_hold",  h0, 1);
      chk("rst_we",    m0.mem_we, 0);
      chk("rst_addr",  m0.mem_addr, 0);
      chk("rst_wdata", m0.mem_wdata, 0);
      chk("rst_instr", in0, NOP);
      chk("rst_iv",    iv0, 0);
      chk("rst_ff",    ff0, 0);
      chk("rst_words", w0, 0);
      chk("rst_ovf",   ov0, 0);
   endtask

   initial begin
      logic [7:0]  bq [$];
      logic [31:0] w;
      int n, nw, k, kind;
      logic coinc;

      rst = 1'b0;
      st0 = 0; bv0 = 0; dn0 = 0; b0 = 0; pc0 = 0;
      st1 = 0; bv1 = 0; dn1 = 0; b1 = 0; pc1 = 0;
      tick(); tick();
      chk_reset0();
      rst = 1'b1;
      tick();

      // load two words, check write timing
      wq0.delete();
      for (int i = 1; i <= 8; i++)
         send0(8'(i), 1'b0);
      chk("t1_we",    m0.mem_we, 1);
      chk("t1_addr",  m0.mem_addr, 1);
      chk("t1_wdata", m0.mem_wdata, 32'h08070605);
      chk("t1_words", w0, 2);
      chk("t1_hold1", h0, 1);
      dn0 = 1'b1; tick(); dn0 = 1'b0;
      chk("t1_hold0", h0, 0);
      chk("t1_iv0",   iv0, 0);
      chk("t1_nwr",   wq0.size(), 2);
      if (wq0.size() == 2) begin
         chk("t1_w0", wq0[0], {10'd0, 32'h04030201});
         chk("t1_w1", wq0[1], {10'd1, 32'h08070605});
      end
      tick();
      chk("t1_iv1",   iv0, 1);
      chk("t1_instr", in0, 32'h04030201);

      // fetches: aligned, misaligned, out of range
      pc0 = 32'h4; tick();
      chk("t3_instr", in0, 32'h08070605);
      chk("t3_iv",    iv0, 1);
      chk("t3_ff",    ff0, 0);
      pc0 = 32'h6; tick();
      chk("t3_mis_i",  in0, NOP);
      chk("t3_mis_ff", ff0, 1);
      chk("t3_mis_iv", iv0, 1);
      pc0 = 32'h1000; tick();
      chk("t3_oob_ff", ff0, 1);
      chk("t3_oob_i",  in0, NOP);

      // ld_start in RUN, then padded reload
      pc0 = 0;
      st0 = 1'b1; tick(); st0 = 1'b0;
      chk("t6_hold", h0, 1);
      chk("t6_iv",   iv0, 0);
      chk("t6_words", w0, 0);
      wq0.delete();
      send0(8'hAA, 0); send0(8'hBB, 0);
      send0(8'hCC, 0); send0(8'hDD, 0);
      send0(8'hEE, 0);
      dn0 = 1'b1; tick(); dn0 = 1'b0;
      chk("t2_we",    m0.mem_we, 1);
      chk("t2_wdata", m0.mem_wdata, 32'h000000EE);
      chk("t2_hold1", h0, 1);
      pc0 = 32'h4;
      tick();
      chk("t2_hold0", h0, 0);
      chk("t2_nwr",   wq0.size(), 2);
      if (wq0.size() == 2) begin
         chk("t2_w0", wq0[0], {10'd0, 32'hDDCCBBAA});
         chk("t2_w1", wq0[1], {10'd1, 32'h000000EE});
      end
      tick();
      chk("t2_fetch", in0, 32'h000000EE);

      // 4th byte coincides with ld_done
      st0 = 1'b1; tick(); st0 = 1'b0;
      wq0.delete();
      send0(8'h10, 0); send0(8'h20, 0);
      send0(8'h30, 0); send0(8'h40, 1);
      chk("t5_we1",  m0.mem_we, 1);
      chk("t5_hold", h0, 1);
      tick();
      chk("t5_we0",   m0.mem_we, 0);
      chk("t5_hold0", h0, 0);
      chk("t5_nwr",   wq0.size(), 1);
      if (wq0.size() == 1)
         chk("t5_w0", wq0[0], {10'd0, 32'h40302010});

      // reset mid-word
      st0 = 1'b1; tick(); st0 = 1'b0;
      send0(8'h99, 0); send0(8'h98, 0);
      #2 rst = 1'b0;
      #1 chk_reset0();
      rst = 1'b1;
      tick();
      wq0.delete();
      send0(8'h11, 0); send0(8'h22, 0);
      send0(8'h33, 0); send0(8'h44, 0);
      chk("t6_addr",  m0.mem_addr, 0);
      chk("t6_wdata", m0.mem_wdata, 32'h44332211);
      dn0 = 1'b1; tick(); dn0 = 1'b0;
      chk("t6_nwr", wq0.size(), 1);

      // overflow on the 4-word instance
      wq1.delete();
      for (int i = 1; i <= 16; i++) send1(8'(i));
      tick();
      chk("t4_ovf0", ov1, 0);
      for (int i = 17; i <= 20; i++) send1(8'(i));
      chk("t4_ovf1",  ov1, 1);
      chk("t4_words", w1, 4);
      chk("t4_nwr",   wq1.size(), 4);
      for (int i = 0; i < 4 && i < wq1.size(); i++) begin
         w = {8'(4*i+4), 8'(4*i+3),
              8'(4*i+2), 8'(4*i+1)};
         chk("t4_wr", wq1[i], {2'(i), w});
      end
      dn1 = 1'b1; tick(); dn1 = 1'b0;
      pc1 = 32'h8;
      tick();
      chk("t4_hold0", h1, 0);
      tick();
      chk("t4_fetch", in1, 32'h0C0B0A09);
      pc1 = 32'h10; tick();
      chk("t4_oob", ff1, 1);
      st1 = 1'b1; tick(); st1 = 1'b0;
      chk("t4_clr_ovf", ov1, 0);
      chk("t4_clr_w",   w1, 0);
      chk("t4_hold1",   h1, 1);

      // randomized loads against the image model
      for (int r = 0; r < 8; r++) begin
         st0 = 1'b1; tick(); st0 = 1'b0;
         wq0.delete();
         bq.delete();
         n = $urandom_range(1, 40);
         coinc = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) begin
            bq.push_back(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            send0(bq[i], coinc && (i == n - 1));
         end
         if (!coinc) begin
            dn0 = 1'b1; tick(); dn0 = 1'b0;
         end
         k = 0;
         while (h0 && k < 10) begin
            tick(); k++;
         end
         chk("rnd_hold", h0, 0);
         nw = (n + 3) / 4;
         chk("rnd_words", w0, 11'(nw));
         chk("rnd_nwr", wq0.size(), nw);
         for (int i = 0; i < nw; i++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++)
               if (4*i + j < n) w[8*j +: 8] = bq[4*i + j];
            ref_img[i] = w;
            if (i < wq0.size())
               chk("rnd_wr", wq0[i], {10'(i), w});
         end
         for (int f = 0; f < 8; f++) begin
            kind = $urandom_range(0, 3);
            k = $urandom_range(0, nw - 1);
            if (kind == 0)
               pc0 = (32'(k) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1)
               pc0 = 32'h1000 + (32'(k) << 2);
            else
               pc0 = 32'(k) << 2;
            tick();
            chk("rnd_iv", iv0, 1);
            chk("rnd_ff", ff0, kind < 2);
            chk("rnd_instr", in0,
                (kind < 2) ? NOP : ref_img[k]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
